// File: rtl/block_assembler_if.sv
// Job-load and block-stream signals between the job loader, the block
// assembler and the hash-core input.
// slave  : the assembler side (takes job controls, produces the block stream)
// master : the job-loader / consumer side
interface block_assembler_if #(
  parameter int ENTRY_BYTES = 12,
  parameter int NONCE_BYTES = 4,
  parameter int CNT_W       = 32
);
  localparam int EW = 8 * ENTRY_BYTES;
  localparam int NW = 8 * NONCE_BYTES;
  localparam int BW = 8 * (ENTRY_BYTES + NONCE_BYTES);

  logic             start;
  logic             stop;
  logic [EW-1:0]    entry;
  logic [NW-1:0]    nonce_first;
  logic [NW-1:0]    nonce_last;
  logic             out_ready;
  logic             out_valid;
  logic [BW-1:0]    block_out;
  logic [NW-1:0]    nonce_out;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] blk_count;
  logic [1:0]       state_dbg;

  modport slave (
    input  start, stop, entry, nonce_first, nonce_last, out_ready,
    output out_valid, block_out, nonce_out, busy, done, aborted, blk_count,
           state_dbg
  );

  modport master (
    output start, stop, entry, nonce_first, nonce_last, out_ready,
    input  out_valid, block_out, nonce_out, busy, done, aborted, blk_count,
           state_dbg
  );
endinterface

// File: rtl/block_assembler.sv
// Block assembler: captures a header entry and an inclusive nonce range, then
// streams one {nonce, entry} / {entry, nonce} block per accepted handshake.
//
// Handshake: a block transfers on a rising edge where out_valid && out_ready.
// out_valid is a flop that depends only on state (never on out_ready); while
// out_valid is high and out_ready is low, block_out/nonce_out hold stable, and
// out_valid only falls after the final transfer or on stop.
module block_assembler #(
  parameter int ENTRY_BYTES = 12,
  parameter int NONCE_BYTES = 4,
  parameter int NONCE_HIGH  = 1,
  parameter int CNT_W       = 32
) (
  input  logic            clk,
  input  logic            reset,
  block_assembler_if.slave bus
);
  localparam int EW = 8 * ENTRY_BYTES;
  localparam int NW = 8 * NONCE_BYTES;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [EW-1:0]    entry_q, entry_d;
  logic [NW-1:0]    cur_nonce_q, cur_nonce_d;
  logic [NW-1:0]    last_nonce_q, last_nonce_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;

  logic             xfer;
  logic             at_last;
  logic [CNT_W-1:0] cnt_inc;

  assign xfer    = valid_q & bus.out_ready;
  assign at_last = (cur_nonce_q == last_nonce_q);
  // Counter saturates at all-ones instead of wrapping.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      entry_q      <= '0;
      cur_nonce_q  <= '0;
      last_nonce_q <= '0;
      cnt_q        <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      entry_q      <= entry_d;
      cur_nonce_q  <= cur_nonce_d;
      last_nonce_q <= last_nonce_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  // Next state: stop beats a simultaneous transfer; start only counts in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.start) state_d = ST_RUN;
      ST_RUN: begin
        if (bus.stop)           state_d = ST_IDLE;
        else if (xfer && at_last) state_d = ST_FINISH;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values for each state.
  always_comb begin
    entry_d      = entry_q;
    cur_nonce_d  = cur_nonce_q;
    last_nonce_d = last_nonce_q;
    cnt_d        = cnt_q;
    valid_d      = valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          entry_d      = bus.entry;
          cur_nonce_d  = bus.nonce_first;
          last_nonce_d = bus.nonce_last;
          cnt_d        = '0;
          valid_d      = 1'b1;
          busy_d       = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          // The block offered this cycle is dropped and not counted.
          valid_d   = 1'b0;
          busy_d    = 1'b0;
          aborted_d = 1'b1;
        end else if (xfer) begin
          cnt_d = cnt_inc;
          if (at_last) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            // Natural modulo-2^NW wrap lets last < first describe a range.
            cur_nonce_d = cur_nonce_q + 1'b1;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Block layout: byte 0 is the LSB; the nonce sits at the top or bottom.
  generate
    if (NONCE_HIGH != 0) begin : g_nonce_high
      assign bus.block_out = {cur_nonce_q, entry_q};
    end else begin : g_nonce_low
      assign bus.block_out = {entry_q, cur_nonce_q};
    end
  endgenerate

  assign bus.nonce_out = cur_nonce_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.aborted   = aborted_q;
  assign bus.blk_count = cnt_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_block_assembler.sv
// Directed bench for block_assembler: three configurations sharing one clock.
module tb_block_assembler;
  logic clk   = 1'b0;
  logic reset = 1'b0;

  // Clock and reset
  always #5 clk = ~clk;

  block_assembler_if #(.ENTRY_BYTES(12), .NONCE_BYTES(4), .CNT_W(32)) a ();
  block_assembler_if #(.ENTRY_BYTES(6),  .NONCE_BYTES(2), .CNT_W(32)) b ();
  block_assembler_if #(.ENTRY_BYTES(1),  .NONCE_BYTES(1), .CNT_W(2))  c ();

  block_assembler #(.ENTRY_BYTES(12), .NONCE_BYTES(4), .NONCE_HIGH(1), .CNT_W(32))
    dut_a (.clk(clk), .reset(reset), .bus(a.slave));
  block_assembler #(.ENTRY_BYTES(6), .NONCE_BYTES(2), .NONCE_HIGH(0), .CNT_W(32))
    dut_b (.clk(clk), .reset(reset), .bus(b.slave));
  block_assembler #(.ENTRY_BYTES(1), .NONCE_BYTES(1), .NONCE_HIGH(1), .CNT_W(2))
    dut_c (.clk(clk), .reset(reset), .bus(c.slave));

  int total = 0;
  int bad   = 0;

  // Scoreboard for config A: expected blocks in transfer order
  logic [127:0] exp_q[$];

  int           steps;
  int           last_xfer_step;
  int           done_cnt;
  int           aborted_cnt;
  int           xfers;
  bit           hold_pending;
  logic [127:0] held_blk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic begin_job();
    steps          = 0;
    last_xfer_step = -10;
    done_cnt       = 0;
    aborted_cnt    = 0;
    xfers          = 0;
    hold_pending   = 1'b0;
  endtask

  // Model of the stream: every nonce from first to last inclusive, wrapping.
  task automatic push_job(input logic [95:0] ent, input logic [31:0] first,
                          input logic [31:0] last, input int max_n);
    logic [31:0] n;
    int k;
    n = first;
    k = 0;
    forever begin
      exp_q.push_back({n, ent});
      k++;
      if (n == last || k >= max_n) break;
      n = n + 32'd1;
    end
  endtask

  // One clock of config A: monitor at the falling edge, return #1 after rise.
  task automatic step();
    logic [127:0] e;
    @(negedge clk);
    steps++;
    if (a.done) begin
      done_cnt++;
      chk("done_timing", steps, last_xfer_step + 1);
    end
    if (a.aborted) aborted_cnt++;
    if (hold_pending) begin
      chk("hold_stable", a.block_out, held_blk);
      hold_pending = 1'b0;
    end
    if (a.out_valid && a.out_ready && !a.stop) begin
      chk("queue_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("nonce_out", a.nonce_out, e[127:96]);
        chk("block_out", a.block_out, e);
      end
      last_xfer_step = steps;
      xfers++;
    end else if (a.out_valid && !a.out_ready) begin
      hold_pending = 1'b1;
      held_blk     = a.block_out;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_end(input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (done_cnt + aborted_cnt > 0) break;
    end
    chk("job_end_seen", done_cnt + aborted_cnt, 1);
  endtask

  task automatic start_a(input logic [95:0] ent, input logic [31:0] first,
                         input logic [31:0] last, input int max_n);
    begin_job();
    push_job(ent, first, last, max_n);
    a.entry       = ent;
    a.nonce_first = first;
    a.nonce_last  = last;
    a.start       = 1'b1;
    step();
    a.start       = 1'b0;
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] n8;
    int         cx;
    bit         c_done;

    a.start = 0; a.stop = 0; a.entry = '0; a.nonce_first = '0; a.nonce_last = '0; a.out_ready = 0;
    b.start = 0; b.stop = 0; b.entry = '0; b.nonce_first = '0; b.nonce_last = '0; b.out_ready = 0;
    c.start = 0; c.stop = 0; c.entry = '0; c.nonce_first = '0; c.nonce_last = '0; c.out_ready = 0;

    // Reset state
    #1 reset = 1'b1;
    #2;
    chk("rst_valid",   a.out_valid, 1'b0);
    chk("rst_busy",    a.busy, 1'b0);
    chk("rst_done",    a.done, 1'b0);
    chk("rst_aborted", a.aborted, 1'b0);
    chk("rst_count",   a.blk_count, 0);
    chk("rst_block",   a.block_out, 0);
    chk("rst_block_b", b.block_out, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Basic stream 5..7
    a.out_ready = 1'b1;
    start_a(96'h0B0A09080706050403020100, 32'd5, 32'd7, 100);
    chk("basic_busy", a.busy, 1'b1);
    chk("basic_state", a.state_dbg, 2'd1);
    run_until_end(20);
    chk("basic_count", a.blk_count, 3);
    chk("basic_xfers", xfers, 3);
    chk("basic_drained", exp_q.size(), 0);
    chk("basic_valid_low", a.out_valid, 1'b0);
    step();

    // Backpressure 0..3 with ready 1,0,0,1,...
    start_a(96'h1111_2222_3333_4444_5555_6666, 32'd0, 32'd3, 100);
    for (int k = 0; k < 40; k++) begin
      a.out_ready = (k % 3 == 0);
      step();
      if (done_cnt > 0) break;
    end
    chk("bp_done", done_cnt, 1);
    chk("bp_xfers", xfers, 4);
    chk("bp_count", a.blk_count, 4);
    chk("bp_drained", exp_q.size(), 0);
    a.out_ready = 1'b1;
    step();

    // Wrap-around FFFFFFFE..1
    start_a(96'hDEAD_BEEF_0123_4567_89AB_CDEF, 32'hFFFF_FFFE, 32'h0000_0001, 100);
    run_until_end(20);
    chk("wrap_count", a.blk_count, 4);
    chk("wrap_xfers", xfers, 4);
    chk("wrap_drained", exp_q.size(), 0);
    step();

    // Abort on the same cycle as the 3rd transfer
    start_a(96'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F, 32'd0, 32'd100, 200);
    step();
    step();
    a.stop = 1'b1;
    step();
    a.stop = 1'b0;
    chk("abort_valid_low", a.out_valid, 1'b0);
    chk("abort_busy_low", a.busy, 1'b0);
    step();
    step();
    step();
    chk("abort_pulses", aborted_cnt, 1);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_xfers", xfers, 2);
    chk("abort_count", a.blk_count, 2);
    exp_q.delete();

    // Reset asserted between edges mid-run
    start_a(96'h0101_0202_0303_0404_0505_0606, 32'd0, 32'd100, 200);
    step();
    step();
    step();
    chk("pre_rst_count", a.blk_count, 3);
    #2 reset = 1'b1;
    #1;
    chk("midrst_valid", a.out_valid, 1'b0);
    chk("midrst_busy", a.busy, 1'b0);
    chk("midrst_count", a.blk_count, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    begin_job();
    step();
    step();
    chk("postrst_no_pulse", done_cnt + aborted_cnt, 0);
    chk("postrst_idle", a.out_valid, 1'b0);
    start_a(96'h0, 32'd9, 32'd9, 100);
    run_until_end(10);
    chk("single_xfers", xfers, 1);
    chk("single_count", a.blk_count, 1);
    chk("single_drained", exp_q.size(), 0);

    // Config B: nonce in low bytes, start held through RUN
    b.entry       = 48'h665544332211;
    b.nonce_first = 16'hABCD;
    b.nonce_last  = 16'hABCD;
    b.out_ready   = 1'b0;
    b.start       = 1'b1;
    @(posedge clk);
    #1;
    chk("b_valid", b.out_valid, 1'b1);
    chk("b_block", b.block_out, 64'h665544332211ABCD);
    chk("b_nonce", b.nonce_out, 16'hABCD);
    b.entry       = 48'hFFEEDDCCBBAA;
    b.nonce_first = 16'h1111;
    b.nonce_last  = 16'h2222;
    repeat (2) @(posedge clk);
    #1;
    chk("b_start_ignored", b.block_out, 64'h665544332211ABCD);
    chk("b_count_held", b.blk_count, 0);
    b.out_ready = 1'b1;
    @(posedge clk);
    #1;
    b.start = 1'b0;
    chk("b_done", b.done, 1'b1);
    chk("b_valid_low", b.out_valid, 1'b0);
    chk("b_count", b.blk_count, 1);
    @(posedge clk);
    #1;
    chk("b_done_pulse", b.done, 1'b0);
    chk("b_idle", b.busy, 1'b0);

    // Config C: full 8-bit range 5..4 and a saturating 2-bit counter
    c.entry       = 8'h3C;
    c.nonce_first = 8'h05;
    c.nonce_last  = 8'h04;
    c.out_ready   = 1'b1;
    c.start       = 1'b1;
    @(posedge clk);
    #1;
    c.start = 1'b0;
    n8      = 8'h05;
    cx      = 0;
    c_done  = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (c.done) begin
        c_done = 1'b1;
        break;
      end
      if (c.out_valid && c.out_ready) begin
        chk("c_block", c.block_out, {n8, 8'h3C});
        n8 = n8 + 8'd1;
        cx++;
      end
      if (cx == 4) chk("c_sat_early", c.blk_count, 2'b11);
    end
    chk("c_done_seen", c_done, 1'b1);
    chk("c_xfers", cx, 256);
    chk("c_sat", c.blk_count, 2'b11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
